// File: rtl/alu_mc.sv
// Multi-cycle ALU for the PIC16-style datapath: single-cycle logic/arith ops plus
// iterative unsigned shift-add multiply and restoring divide, with registered results.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] op_w,
  input  logic [WIDTH-1:0] op_lf,
  input  logic             carry_in,
  input  logic             alu_d,
  input  logic             alu_d_wr_en,
  input  logic             alu_status_wr_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] alu_out_hi,
  output logic             alu_out_w_wr_en,
  output logic             alu_out_f_wr_en,
  output logic             alu_out_z,
  output logic             alu_out_dc,
  output logic             alu_out_c,
  output logic             alu_out_z_wr_en,
  output logic             alu_out_dc_wr_en,
  output logic             alu_out_c_wr_en
);

  localparam int HALF = WIDTH / 2;
  localparam int CW   = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_AND, OP_CLR, OP_COM, OP_DEC, OP_INC, OP_OR, OP_PASSLF,
    OP_PASSW, OP_RLF, OP_RRF, OP_SUB, OP_SWAPF, OP_XOR, OP_MUL, OP_DIV
  } op_t;

  state_t           r_state, w_state_nxt;
  op_t              w_op;
  logic             w_is_multi, w_accept;
  logic [CW-1:0]    r_cnt;
  logic             r_is_div;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH-1:0] r_lo, r_opnd;
  logic             r_d, r_d_wr_en, r_st_wr_en;
  logic [2:0]       r_fmask;  // {z, dc, c}
  logic [WIDTH-1:0] r_out, r_out_hi;
  logic             r_z, r_dc, r_c;

  logic [WIDTH-1:0] w_res;
  logic [WIDTH:0]   w_sum;
  logic [4:0]       w_nib;
  logic             w_c, w_dc, w_z;
  logic [2:0]       w_mask;

  logic [WIDTH:0]   w_madd, w_rsh, w_hi_nxt;
  logic [WIDTH-1:0] w_lo_nxt;
  logic             w_ge;

  assign w_op       = op_t'(op);
  assign w_is_multi = (w_op == OP_MUL) || (w_op == OP_DIV);
  assign w_accept   = (r_state == S_IDLE) && start;

  // Single-cycle result, evaluated straight from the inputs at the accepting edge.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_res  = '0;
    w_c    = 1'b0;
    w_dc   = 1'b0;
    w_mask = 3'b000;
    w_sum  = {1'b0, op_w} + {1'b0, op_lf};
    w_nib  = {1'b0, op_w[3:0]} + {1'b0, op_lf[3:0]};
    case (w_op)
      OP_ADD:    begin w_res = w_sum[WIDTH-1:0]; w_c = w_sum[WIDTH]; w_dc = w_nib[4]; w_mask = 3'b111; end
      OP_AND:    begin w_res = op_w & op_lf;          w_mask = 3'b100; end
      OP_CLR:    begin w_res = '0;                    w_mask = 3'b100; end
      OP_COM:    begin w_res = ~op_lf;                w_mask = 3'b100; end
      OP_DEC:    begin w_res = op_lf - WIDTH'(1);     w_mask = 3'b100; end
      OP_INC:    begin w_res = op_lf + WIDTH'(1);     w_mask = 3'b100; end
      OP_OR:     begin w_res = op_w | op_lf;          w_mask = 3'b100; end
      OP_PASSLF: begin w_res = op_lf;                 w_mask = 3'b100; end
      OP_PASSW:  begin w_res = op_w;                  w_mask = 3'b100; end
      OP_RLF:    begin w_res = {op_lf[WIDTH-2:0], carry_in}; w_c = op_lf[WIDTH-1]; w_mask = 3'b001; end
      OP_RRF:    begin w_res = {carry_in, op_lf[WIDTH-1:1]}; w_c = op_lf[0];       w_mask = 3'b001; end
      OP_SUB:    begin
        w_res  = op_lf - op_w;
        w_c    = (op_lf >= op_w);
        w_dc   = (op_lf[3:0] >= op_w[3:0]);
        w_mask = 3'b111;
      end
      OP_SWAPF:  w_res = {op_lf[HALF-1:0], op_lf[WIDTH-1:HALF]};
      OP_XOR:    begin w_res = op_w ^ op_lf;          w_mask = 3'b100; end
      OP_MUL, OP_DIV: w_mask = 3'b101;
      default:   w_mask = 3'b000;
    endcase
  end
  assign w_z = (w_res == '0);

  // One iteration step: shift-add for mul, restoring shift-subtract for div.
  always_comb begin
    w_madd   = r_lo[0] ? (r_hi + {1'b0, r_opnd}) : r_hi;
    w_rsh    = {r_hi[WIDTH-1:0], r_lo[WIDTH-1]};
    w_ge     = (w_rsh >= {1'b0, r_opnd});
    w_hi_nxt = {1'b0, w_madd[WIDTH:1]};
    w_lo_nxt = {w_madd[0], r_lo[WIDTH-1:1]};
    if (r_is_div) begin
      w_hi_nxt = w_ge ? (w_rsh - {1'b0, r_opnd}) : w_rsh;
      w_lo_nxt = {r_lo[WIDTH-2:0], w_ge};
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_is_multi ? S_ITER : S_DONE;
      S_ITER:  if (r_cnt == CW'(1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;  r_is_div <= 1'b0;
      r_hi  <= '0;  r_lo <= '0;  r_opnd <= '0;
      r_d   <= 1'b0; r_d_wr_en <= 1'b0; r_st_wr_en <= 1'b0; r_fmask <= '0;
      r_out <= '0;  r_out_hi <= '0;
      r_z   <= 1'b0; r_dc <= 1'b0; r_c <= 1'b0;
    end else if (w_accept) begin
      r_d        <= alu_d;
      r_d_wr_en  <= alu_d_wr_en;
      r_st_wr_en <= alu_status_wr_en;
      r_fmask    <= w_mask;
      r_is_div   <= (w_op == OP_DIV);
      r_cnt      <= CW'(WIDTH);
      r_hi       <= '0;
      r_lo       <= op_lf;
      r_opnd     <= op_w;
      if (!w_is_multi) begin
        r_out    <= w_res;
        r_out_hi <= '0;
        r_z      <= w_z;
        r_dc     <= w_dc;
        r_c      <= w_c;
      end
    end else if (r_state == S_ITER) begin
      r_cnt <= r_cnt - CW'(1);
      r_hi  <= w_hi_nxt;
      r_lo  <= w_lo_nxt;
      if (r_cnt == CW'(1)) begin
        r_out    <= w_lo_nxt;
        r_out_hi <= w_hi_nxt[WIDTH-1:0];
        r_dc     <= 1'b0;
        if (r_is_div) begin
          // A zero divisor naturally yields all-ones quotient and remainder = dividend.
          r_z <= (w_lo_nxt == '0);
          r_c <= (r_opnd != '0);
        end else begin
          r_z <= (w_hi_nxt == '0) && (w_lo_nxt == '0);
          r_c <= (w_hi_nxt != '0);
        end
      end
    end
  end

  always_comb begin
    busy             = (r_state == S_ITER);
    done             = (r_state == S_DONE);
    alu_out_w_wr_en  = done & r_d_wr_en & ~r_d;
    alu_out_f_wr_en  = done & r_d_wr_en &  r_d;
    alu_out_z_wr_en  = done & r_st_wr_en & r_fmask[2];
    alu_out_dc_wr_en = done & r_st_wr_en & r_fmask[1];
    alu_out_c_wr_en  = done & r_st_wr_en & r_fmask[0];
  end

  assign alu_out    = r_out;
  assign alu_out_hi = r_out_hi;
  assign alu_out_z  = r_z;
  assign alu_out_dc = r_dc;
  assign alu_out_c  = r_c;

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=8): single-cycle ops, mul/div timing, ignored
// start during iteration, divide by zero and asynchronous reset abort.
module tb_alu_mc;

  logic       clk, rst, start;
  logic [3:0] op;
  logic [7:0] op_w, op_lf;
  logic       carry_in, alu_d, alu_d_wr_en, alu_status_wr_en;
  logic       busy, done;
  logic [7:0] alu_out, alu_out_hi;
  logic       alu_out_w_wr_en, alu_out_f_wr_en;
  logic       alu_out_z, alu_out_dc, alu_out_c;
  logic       alu_out_z_wr_en, alu_out_dc_wr_en, alu_out_c_wr_en;

  logic [4:0] stb;    // {z_wr, dc_wr, c_wr, w_wr, f_wr}
  logic [2:0] flags;  // {z, dc, c}
  assign stb   = {alu_out_z_wr_en, alu_out_dc_wr_en, alu_out_c_wr_en, alu_out_w_wr_en, alu_out_f_wr_en};
  assign flags = {alu_out_z, alu_out_dc, alu_out_c};

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .op_w(op_w), .op_lf(op_lf),
    .carry_in(carry_in), .alu_d(alu_d), .alu_d_wr_en(alu_d_wr_en),
    .alu_status_wr_en(alu_status_wr_en), .busy(busy), .done(done),
    .alu_out(alu_out), .alu_out_hi(alu_out_hi),
    .alu_out_w_wr_en(alu_out_w_wr_en), .alu_out_f_wr_en(alu_out_f_wr_en),
    .alu_out_z(alu_out_z), .alu_out_dc(alu_out_dc), .alu_out_c(alu_out_c),
    .alu_out_z_wr_en(alu_out_z_wr_en), .alu_out_dc_wr_en(alu_out_dc_wr_en),
    .alu_out_c_wr_en(alu_out_c_wr_en)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Waits for an idle cycle, presents one start pulse, then scrambles the inputs.
  // Returns #1 after the accepting edge N, i.e. in cycle N+1.
  task automatic launch(input logic [3:0] o, input logic [7:0] w, input logic [7:0] lf,
                        input logic c, input logic d, input logic dwr, input logic swr);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; op = o; op_w = w; op_lf = lf;
    carry_in = c; alu_d = d; alu_d_wr_en = dwr; alu_status_wr_en = swr;
    @(posedge clk);
    #1;
    start = 1'b0; op = 4'h2; op_w = 8'h00; op_lf = 8'h00;
    carry_in = ~c; alu_d = ~d; alu_d_wr_en = ~dwr; alu_status_wr_en = ~swr;
  endtask

  // Counts the cycle index (relative to the accepting edge) at which done appears.
  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; start = 1'b0; op = 4'h0; op_w = 8'h00; op_lf = 8'h00;
    carry_in = 1'b0; alu_d = 1'b0; alu_d_wr_en = 1'b0; alu_status_wr_en = 1'b0;
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, stb, flags} !== 10'b0) begin
      n_fail++; $display("FAIL reset_ctrl got=%b exp=%b", {busy, done, stb, flags}, 10'b0);
    end
    n_checks++;
    if ({alu_out, alu_out_hi} !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data got=%h exp=%h", {alu_out, alu_out_hi}, 16'h0000);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    launch(4'h0, 8'h0F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL add_done got=%b exp=%b", {busy, done}, 2'b01); end
    n_checks++;
    if (alu_out !== 8'h10) begin n_fail++; $display("FAIL add_out got=%h exp=%h", alu_out, 8'h10); end
    n_checks++;
    if (flags !== 3'b010) begin n_fail++; $display("FAIL add_flags got=%b exp=%b", flags, 3'b010); end
    n_checks++;
    if (stb !== 5'b11101) begin n_fail++; $display("FAIL add_stb got=%b exp=%b", stb, 5'b11101); end
    @(posedge clk);
    #1;
    n_checks++;
    if ({done, stb} !== 6'b0) begin n_fail++; $display("FAIL add_one_cycle got=%b exp=%b", {done, stb}, 6'b0); end
    n_checks++;
    if (alu_out !== 8'h10) begin n_fail++; $display("FAIL add_hold got=%h exp=%h", alu_out, 8'h10); end
  endtask

  task automatic test_sub;
    launch(4'hB, 8'h06, 8'h05, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({done, alu_out} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL sub_borrow_out got=%b/%h exp=1/ff", done, alu_out); end
    n_checks++;
    if (flags !== 3'b000) begin n_fail++; $display("FAIL sub_borrow_flags got=%b exp=%b", flags, 3'b000); end
    n_checks++;
    if (stb !== 5'b11110) begin n_fail++; $display("FAIL sub_stb got=%b exp=%b", stb, 5'b11110); end
    launch(4'hB, 8'h06, 8'h06, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if (alu_out !== 8'h00) begin n_fail++; $display("FAIL sub_eq_out got=%h exp=%h", alu_out, 8'h00); end
    n_checks++;
    if (flags !== 3'b111) begin n_fail++; $display("FAIL sub_eq_flags got=%b exp=%b", flags, 3'b111); end
  endtask

  task automatic test_rotate;
    launch(4'h9, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({alu_out, alu_out_c} !== {8'h01, 1'b1}) begin n_fail++; $display("FAIL rlf got=%h/%b exp=01/1", alu_out, alu_out_c); end
    n_checks++;
    if (stb !== 5'b00110) begin n_fail++; $display("FAIL rlf_stb got=%b exp=%b", stb, 5'b00110); end
    launch(4'hA, 8'h00, 8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({alu_out, alu_out_c} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL rrf got=%h/%b exp=00/1", alu_out, alu_out_c); end
    n_checks++;
    if (stb !== 5'b00110) begin n_fail++; $display("FAIL rrf_stb got=%b exp=%b", stb, 5'b00110); end
  endtask

  task automatic test_logic;
    launch(4'hD, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({alu_out, alu_out_z, stb} !== {8'h00, 1'b1, 5'b10000}) begin
      n_fail++; $display("FAIL xor got=%h/%b/%b exp=00/1/10000", alu_out, alu_out_z, stb);
    end
    launch(4'hC, 8'h00, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({alu_out, stb} !== {8'h5A, 5'b00001}) begin
      n_fail++; $display("FAIL swapf got=%h/%b exp=5a/00001", alu_out, stb);
    end
    launch(4'h2, 8'h33, 8'h44, 1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({alu_out, alu_out_z, stb} !== {8'h00, 1'b1, 5'b00001}) begin
      n_fail++; $display("FAIL clr got=%h/%b/%b exp=00/1/00001", alu_out, alu_out_z, stb);
    end
  endtask

  task automatic test_mul;
    int bad_busy;
    bad_busy = 0;
    launch(4'hE, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1);
    if (!(busy && !done)) bad_busy++;
    for (int k = 2; k <= 8; k++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (!(busy && !done)) bad_busy++;
      if (k == 3) begin
        start = 1'b1; op = 4'h0; op_w = 8'h01; op_lf = 8'h01;
      end
    end
    n_checks++;
    if (bad_busy !== 0) begin n_fail++; $display("FAIL mul_busy_window got=%0d exp=0", bad_busy); end
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b01) begin n_fail++; $display("FAIL mul_done_n9 got=%b exp=%b", {busy, done}, 2'b01); end
    n_checks++;
    if ({alu_out_hi, alu_out} !== 16'hFE01) begin n_fail++; $display("FAIL mul_product got=%h exp=%h", {alu_out_hi, alu_out}, 16'hFE01); end
    n_checks++;
    if ({alu_out_z, alu_out_c, stb} !== {1'b0, 1'b1, 5'b10110}) begin
      n_fail++; $display("FAIL mul_flags got=%b%b/%b exp=01/10110", alu_out_z, alu_out_c, stb);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL mul_start_ignored got=%b exp=%b", {busy, done}, 2'b00); end
  endtask

  task automatic test_div;
    int cyc;
    launch(4'hF, 8'h07, 8'hC8, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL div_latency got=%0d exp=9", cyc); end
    n_checks++;
    if ({alu_out, alu_out_hi, alu_out_z, alu_out_c} !== {8'h1C, 8'h04, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL div_200_7 got=%h/%h/%b%b exp=1c/04/01", alu_out, alu_out_hi, alu_out_z, alu_out_c);
    end
    launch(4'hF, 8'h00, 8'h55, 1'b0, 1'b1, 1'b1, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 9) begin n_fail++; $display("FAIL div0_latency got=%0d exp=9", cyc); end
    n_checks++;
    if ({alu_out, alu_out_hi, alu_out_z, alu_out_c} !== {8'hFF, 8'h55, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL div0 got=%h/%h/%b%b exp=ff/55/00", alu_out, alu_out_hi, alu_out_z, alu_out_c);
    end
    n_checks++;
    if (stb !== 5'b10101) begin n_fail++; $display("FAIL div0_stb got=%b exp=%b", stb, 5'b10101); end
  endtask

  task automatic test_reset_abort;
    int seen;
    seen = 0;
    launch(4'hE, 8'h03, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({busy, done, stb, alu_out, alu_out_hi, flags} !== 26'b0) begin
      n_fail++; $display("FAIL abort_async got=%b/%b/%h/%h/%b exp=all zero", busy, done, alu_out, alu_out_hi, flags);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      if (busy || done || (stb != 5'b0)) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL abort_no_strobe got=%0d exp=0", seen); end
    launch(4'h5, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if ({done, alu_out, alu_out_z, stb} !== {1'b1, 8'h00, 1'b1, 5'b10001}) begin
      n_fail++; $display("FAIL inc_after_reset got=%b/%h/%b/%b exp=1/00/1/10001", done, alu_out, alu_out_z, stb);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_rotate();
    test_logic();
    test_mul();
    test_div();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, width-parametrised successor to the core ALU for the PIC16-style datapath. It computes every existing single-cycle operation, with true rotate-through-carry and PIC-convention borrow flags, and adds iterative unsigned multiply and divide. Results, flags and destination write enables are registered and presented for one cycle on `done`. It sits between the W/regfile operand muxes and the W, regfile and STATUS write ports; the control FSM stalls on `busy`.

## Interface
Parameters:
- `WIDTH`, default 8: operand/result width; must be even and ≥ 8.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: launch operation; sampled only when idle.
- `op` in 4: operation code.
- `op_w` in WIDTH: W operand.
- `op_lf` in WIDTH: literal or register-f operand.
- `carry_in` in 1: current STATUS.C, used by rotates.
- `alu_d` in 1: destination select, 0 = W, 1 = f.
- `alu_d_wr_en` in 1: destination write request.
- `alu_status_wr_en` in 1: flag write request.
- `busy` out 1: multi-cycle op in progress.
- `done` out 1: one-cycle result strobe.
- `alu_out` out WIDTH: result; product low half; quotient.
- `alu_out_hi` out WIDTH: product high half; remainder; 0 otherwise.
- `alu_out_w_wr_en`, `alu_out_f_wr_en` out 1 each: destination strobes.
- `alu_out_z`, `alu_out_dc`, `alu_out_c` out 1 each: flag values.
- `alu_out_z_wr_en`, `alu_out_dc_wr_en`, `alu_out_c_wr_en` out 1 each: flag strobes.

## Operation
- Op codes: 0 add, 1 and, 2 clr, 3 com, 4 dec, 5 inc, 6 or, 7 passlf, 8 passw, 9 rlf, A rrf, B sub, C swapf, D xor, E mul, F div.
- At accepted `start`, capture `op`, operands, `carry_in`, `alu_d`, `alu_d_wr_en` and `alu_status_wr_en`. Later input changes have no effect.
- States:
  - IDLE: on `start`, a single-cycle op goes to DONE and a mul/div op goes to ITER.
  - ITER: runs WIDTH iterations with the counter loaded to WIDTH. When the counter reaches 0, go to DONE.
  - DONE: lasts one cycle, then returns to IDLE.
- `start` while in ITER or DONE is ignored; it is not queued.
- Arithmetic is modulo 2^WIDTH. Z = (`alu_out` == 0) unless stated otherwise.
- add:
  - C = carry out of the MSB.
  - DC = carry out of bit 3.
  - Z, C and DC are all written.
- sub (`op_lf` − `op_w`):
  - C = 1 when there is no borrow (`op_lf` ≥ `op_w`).
  - DC = 1 when there is no borrow from the low nibble.
  - Z, C and DC are all written.
- and/or/xor/com/dec/inc/passlf/passw: write Z only.
- clr: `alu_out` = 0, Z = 1, writes Z.
- rlf: `{C, alu_out}` = `{op_lf, carry_in}`; writes C only.
- rrf: `{alu_out, C}` = `{carry_in, op_lf}`; writes C only.
- swapf: swaps the upper and lower WIDTH/2 halves; writes no flags.
- mul: unsigned shift-add, one bit per ITER cycle.
  - `{alu_out_hi, alu_out}` = `op_w` × `op_lf`.
  - Z = full product == 0.
  - C = (`alu_out_hi` ≠ 0).
  - Writes Z and C.
- div: restoring division, `op_lf` / `op_w`, one bit per cycle.
  - `alu_out` = quotient, `alu_out_hi` = remainder.
  - Z = quotient == 0, C = 1.
  - Writes Z and C.
- div by zero: still takes WIDTH cycles.
  - `alu_out` = all ones, `alu_out_hi` = `op_lf`.
  - Z = 0, C = 0.
- Flag strobes = captured `alu_status_wr_en` ANDed with the op's flag set, asserted only in DONE.
- `alu_out_w_wr_en` = captured `alu_d_wr_en` & !`alu_d`, asserted only in DONE.
- `alu_out_f_wr_en` = captured `alu_d_wr_en` & `alu_d`, asserted only in DONE.

## Timing
- Reset: state = IDLE. `busy`, `done`, all strobes, `alu_out`, `alu_out_hi` and all flags = 0, applied immediately (asynchronous). Reset mid-ITER aborts with no strobe.
- Single-cycle op, `start` at edge N: `done` and results valid in cycle N+1; `busy` never asserts.
- mul/div, `start` at edge N: `busy` high in cycles N+1..N+WIDTH; `done` in cycle N+WIDTH+1 (N+9 for WIDTH=8).
- `done` and all strobes are high for exactly one cycle.
- `alu_out`, `alu_out_hi` and flag values hold until the next DONE.
- The earliest next `start` is accepted in the DONE cycle's successor, i.e. when the state is IDLE.
- No combinational path from inputs to outputs.

## Test plan
- add, `op_w`=0x0F, `op_lf`=0x01, status_wr_en=1, d=1: cycle N+1 gives `done`, `alu_out`=0x10, DC=1, C=0, Z=0, Z/DC/C strobes=1, f_wr_en=1, w_wr_en=0.
- sub, `op_lf`=0x05, `op_w`=0x06: 0xFF, C=0, DC=0, Z=0. Then `op_lf`=`op_w`=0x06: 0x00, Z=1, C=1, DC=1.
- rlf, 0x80, `carry_in`=1: `alu_out`=0x01, C=1, only the C strobe set. Then rrf, 0x01, `carry_in`=0: 0x00, C=1.
- mul 0xFF×0xFF: `busy` N+1..N+8, `done` N+9, `alu_out`=0x01, `alu_out_hi`=0xFE, C=1, Z=0. A `start` (add) pulsed at N+3 is ignored.
- div 200/7: `alu_out`=0x1C, `alu_out_hi`=0x04, C=1. Then 0x55/0: `alu_out`=0xFF, `alu_out_hi`=0x55, C=0, Z=0, `done` at N+9.
- `rst` asserted asynchronously at N+4 of a mul: `busy`/`done`/outputs go to 0 immediately and no strobe is produced. A new inc 0xFF after release gives 0x00, Z=1 at start+1.
